// File: rtl/div_ctrl_arb.sv
// rtl/div_ctrl_arb.sv - two-requester arbiter around an 8/4-bit restoring divider
// Optional round-robin arbitration: DIV_CTRL_ARB_RR_EN (undefined = fixed priority, requester 0 wins).
module div_ctrl_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] a0,
    input  logic [3:0] b0,
    input  logic [7:0] a1,
    input  logic [3:0] b1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_q,
    output logic [3:0] rsp_r,
    output logic [1:0] rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [4:0] p;
    logic [3:0] q;
    logic [3:0] b_r;
    logic [2:0] count;
    logic [1:0] err_r;

    logic [1:0] grant;
    logic       gid;
    logic [7:0] a_sel;
    logic [3:0] b_sel;
    logic [4:0] p_shift;
    logic [5:0] trial;
    logic [4:0] p_next;
    logic [3:0] q_next;

`ifdef DIV_CTRL_ARB_RR_EN
    logic last;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end
`else
    always_comb begin
        grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
    end
`endif

    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign gid       = grant[1];
    assign a_sel     = gid ? a1 : a0;
    assign b_sel     = gid ? b1 : b0;

    // One restoring step: shift in the next dividend bit, keep the trial difference only if it did not borrow.
    always_comb begin
        p_shift = {p[3:0], q[3]};
        trial   = {1'b0, p_shift} - {2'b00, b_r};
        if (!trial[5]) begin
            p_next = trial[4:0];
            q_next = {q[2:0], 1'b1};
        end else begin
            p_next = p_shift;
            q_next = {q[2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_q     <= 4'd0;
            rsp_r     <= 4'd0;
            rsp_err   <= 2'b00;
            busy      <= 1'b0;
            p         <= 5'd0;
            q         <= 4'd0;
            b_r       <= 4'd0;
            count     <= 3'd0;
            err_r     <= 2'b00;
`ifdef DIV_CTRL_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        rsp_id <= gid;
                        b_r    <= b_sel;
                        p      <= {1'b0, a_sel[7:4]};
                        q      <= a_sel[3:0];
                        count  <= 3'd4;
                        if (b_sel == 4'd0)
                            err_r <= 2'b01;
                        else if (a_sel[7:4] >= b_sel)
                            err_r <= 2'b10;
                        else
                            err_r <= 2'b00;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef DIV_CTRL_ARB_RR_EN
                        last   <= gid;
`endif
                    end
                end
                RUN: begin
                    // Error cases spend a single RUN cycle so their response lands one edge after accept.
                    if (err_r != 2'b00) begin
                        rsp_q     <= 4'd0;
                        rsp_r     <= 4'd0;
                        rsp_err   <= err_r;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        p     <= p_next;
                        q     <= q_next;
                        count <= count - 3'd1;
                        if (count == 3'd1) begin
                            rsp_q     <= q_next;
                            rsp_r     <= p_next[3:0];
                            rsp_err   <= 2'b00;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl_arb.sv
// tb/tb_div_ctrl_arb.sv - randomized self-checking bench for div_ctrl_arb against an arithmetic reference
module tb_div_ctrl_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] a0, a1;
    logic [3:0] b0, b1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_q;
    logic [3:0] rsp_r;
    logic [1:0] rsp_err;
    logic       busy;

    int   total = 0;
    int   bad   = 0;
    logic m_last;

    div_ctrl_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] rv);
        if (rv != 2'b11)
            return rv;
`ifdef DIV_CTRL_ARB_RR_EN
        return m_last ? 2'b01 : 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    function automatic void model_div(input logic [7:0] a, input logic [3:0] b,
                                      output logic [3:0] qo, output logic [3:0] ro,
                                      output logic [1:0] eo);
        int ai = a;
        int bi = b;
        qo = 4'd0;
        ro = 4'd0;
        eo = 2'b00;
        if (bi == 0)
            eo = 2'b01;
        else if (ai >= 16 * bi)
            eo = 2'b10;
        else begin
            qo = 4'(ai / bi);
            ro = 4'(ai % bi);
        end
    endfunction

    // Called at a negedge with the DUT idle; leaves the DUT idle at a negedge.
    task automatic do_op(input logic [1:0] rv, input logic [7:0] x0, input logic [3:0] y0,
                         input logic [7:0] x1, input logic [3:0] y1, input int stall);
        logic [1:0] g;
        logic       id;
        logic [3:0] eq, er;
        logic [1:0] ee;
        int         lat, bcnt, elat;
        g = model_grant(rv);
        id = g[1];
        req_valid = rv;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        rsp_ready = (stall == 0);
        #1;
        chk("req_ready", 32'(req_ready), 32'(g));
        if (id) model_div(x1, y1, eq, er, ee);
        else    model_div(x0, y0, eq, er, ee);
        elat = (ee != 2'b00) ? 1 : 4;
        m_last = id;
        @(negedge clk);
        req_valid = 2'b00;
        a0 = 8'($urandom); b0 = 4'($urandom); a1 = 8'($urandom); b1 = 4'($urandom);
        lat = 0;
        bcnt = int'(busy);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            bcnt += int'(busy);
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_q", 32'(rsp_q), 32'(eq));
        chk("rsp_r", 32'(rsp_r), 32'(er));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        if (stall > 0) begin
            req_valid = 2'b11;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                bcnt += int'(busy);
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_qr", {24'd0, rsp_q, rsp_r}, {24'd0, eq, er});
                chk("hold_err_id", {29'd0, rsp_err, rsp_id}, {29'd0, ee, id});
                chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        req_valid = 2'b00;
        bcnt += int'(busy);
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("busy_cycles", 32'(bcnt), 32'(elat + 1 + stall));
    endtask

    initial begin
        int cyc;
        logic [1:0] g;
        logic       seen;
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        a0 = 8'd0; b0 = 4'd0; a1 = 8'd0; b1 = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_outs", {21'd0, rsp_id, rsp_q, rsp_r, rsp_err}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req_valid = 2'b00;
        m_last = 1'b1;
        @(negedge clk);

        do_op(2'b01, 8'd100, 4'd7, 8'd0, 4'd0, 0);
        do_op(2'b10, 8'd0, 4'd0, 8'd200, 4'd13, 0);
        do_op(2'b10, 8'd0, 4'd0, 8'hF0, 4'd3, 0);
        do_op(2'b01, 8'd55, 4'd0, 8'd0, 4'd0, 0);
        do_op(2'b01, 8'd0, 4'd9, 8'd0, 4'd0, 0);
        do_op(2'b01, 8'd100, 4'd7, 8'd0, 4'd0, 10);

        // Abort during the second RUN cycle.
        req_valid = 2'b01; a0 = 8'd100; b0 = 4'd7; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("abort_outs", {20'd0, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err}, 32'd0);
        chk("abort_busy_ready", {29'd0, busy, req_ready}, 32'd0);
        rst = 1'b0;
        req_valid = 2'b00;
        m_last = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        do_op(2'b11, 8'd9, 4'd2, 8'd77, 4'd5, 0);

        // Both requesters continuously valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        req_valid = 2'b11;
        a0 = 8'd100; b0 = 4'd7; a1 = 8'd100; b1 = 4'd7;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!rsp_valid && cyc < 30);
            g = model_grant(2'b11);
            m_last = g[1];
            chk("cont_id", 32'(rsp_id), 32'(g[1]));
            chk("cont_qr", {24'd0, rsp_q, rsp_r}, {24'd0, 4'd14, 4'd2});
            if (i > 0)
                chk("cont_period", 32'(cyc), 32'd6);
            if (i == 5)
                req_valid = 2'b00;
        end
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom_range(1, 3)), 8'($urandom), 4'($urandom),
                  8'($urandom), 4'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
